// File: rtl/acc_spi_reader.sv
`default_nettype none
// ============================================================================
// Module   : acc_spi_reader
// Purpose  : Mode-3 SPI master that periodically reads one signed 16-bit
//            acceleration register and presents it as a held sample + strobe.
// Revision : 1.0  initial release
// ============================================================================
module acc_spi_reader #(
    parameter int          CLK_DIV       = 4,
    parameter int          SAMPLE_PERIOD = 1000,
    parameter logic [6:0]  REG_ADDR      = 7'h3B
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        enable,
    input  logic        spi_miso,
    output logic        spi_sclk,
    output logic        spi_cs_n,
    output logic        spi_mosi,
    output logic [15:0] acc_out,
    output logic        acc_valid,
    output logic        busy,
    output logic        overrun
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int TMR_W = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
    localparam logic [DIV_W-1:0] C_DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [TMR_W-1:0] C_TMR_LAST = TMR_W'(SAMPLE_PERIOD - 1);
    localparam logic [4:0]       C_LAST_BIT = 5'd23;
    localparam logic [23:0]      C_TX_FRAME = {1'b1, REG_ADDR, 16'h0000};

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SETUP = 3'd1,
        S_SHIFT = 3'd2,
        S_HOLD  = 3'd3,
        S_GAP   = 3'd4
    } state_t;

    state_t             r_state, w_state;
    logic [DIV_W-1:0]   r_div, w_div;
    logic [4:0]         r_bit, w_bit;
    logic [22:0]        r_tx, w_tx;
    logic [15:0]        r_rx, w_rx;
    logic [15:0]        r_acc, w_acc;
    logic [TMR_W-1:0]   r_timer;
    logic               r_sclk, w_sclk;
    logic               r_cs_n, w_cs_n;
    logic               r_mosi, w_mosi;
    logic               r_busy, w_busy;
    logic               r_valid, w_valid;
    logic               w_trigger;
    logic               w_div_last;

    assign w_trigger  = enable && (r_timer == '0);
    assign w_div_last = (r_div == C_DIV_LAST);

    // Free-running sample timer; held at zero so re-enabling triggers at once.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_timer <= '0;
        end else if (!enable || r_timer == C_TMR_LAST) begin
            r_timer <= '0;
        end else begin
            r_timer <= r_timer + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
            r_div   <= '0;
            r_bit   <= '0;
            r_tx    <= '0;
            r_rx    <= '0;
            r_acc   <= '0;
            r_sclk  <= 1'b1;
            r_cs_n  <= 1'b1;
            r_mosi  <= 1'b0;
            r_busy  <= 1'b0;
            r_valid <= 1'b0;
        end else begin
            r_state <= w_state;
            r_div   <= w_div;
            r_bit   <= w_bit;
            r_tx    <= w_tx;
            r_rx    <= w_rx;
            r_acc   <= w_acc;
            r_sclk  <= w_sclk;
            r_cs_n  <= w_cs_n;
            r_mosi  <= w_mosi;
            r_busy  <= w_busy;
            r_valid <= w_valid;
        end
    end

    always_comb begin
        w_state = r_state;
        w_div   = r_div;
        w_bit   = r_bit;
        w_tx    = r_tx;
        w_rx    = r_rx;
        w_acc   = r_acc;
        w_sclk  = r_sclk;
        w_cs_n  = r_cs_n;
        w_mosi  = r_mosi;
        w_busy  = r_busy;
        w_valid = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_trigger) begin
                    w_state = S_SETUP;
                    w_div   = '0;
                    w_bit   = '0;
                    w_tx    = C_TX_FRAME[22:0];
                    w_mosi  = C_TX_FRAME[23];
                    w_sclk  = 1'b1;
                    w_cs_n  = 1'b0;
                    w_busy  = 1'b1;
                end
            end
            S_SETUP: begin
                w_div = r_div + 1'b1;
                if (w_div_last) begin
                    w_div   = '0;
                    w_state = S_SHIFT;
                    w_sclk  = 1'b0;
                end
            end
            S_SHIFT: begin
                w_div = r_div + 1'b1;
                if (w_div_last) begin
                    w_div = '0;
                    if (!r_sclk) begin
                        w_sclk = 1'b1;
                        w_rx   = {r_rx[14:0], spi_miso};
                    end else if (r_bit == C_LAST_BIT) begin
                        w_state = S_HOLD;
                    end else begin
                        // Next bit launches on the falling SCLK edge.
                        w_bit  = r_bit + 1'b1;
                        w_sclk = 1'b0;
                        w_mosi = r_tx[22];
                        w_tx   = {r_tx[21:0], 1'b0};
                    end
                end
            end
            S_HOLD: begin
                w_div = r_div + 1'b1;
                if (w_div_last) begin
                    w_div   = '0;
                    w_state = S_GAP;
                    w_cs_n  = 1'b1;
                    w_busy  = 1'b0;
                    w_mosi  = 1'b0;
                    w_acc   = r_rx;
                    w_valid = 1'b1;
                end
            end
            S_GAP: begin
                w_div = r_div + 1'b1;
                if (w_div_last) begin
                    w_div   = '0;
                    w_state = S_IDLE;
                end
            end
            default: begin
                w_state = S_IDLE;
            end
        endcase
    end

    assign spi_sclk  = r_sclk;
    assign spi_cs_n  = r_cs_n;
    assign spi_mosi  = r_mosi;
    assign acc_out   = r_acc;
    assign acc_valid = r_valid;
    assign busy      = r_busy;
    assign overrun   = w_trigger && (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_acc_spi_reader.sv
`default_nettype none
// ============================================================================
// Module   : tb_acc_spi_reader
// Purpose  : Directed/random bench for acc_spi_reader with a bit-level sensor model.
// Revision : 1.0  initial release
// ============================================================================
module tb_acc_spi_reader;

    logic        clk = 1'b0;
    logic [2:0]  rst_n;
    logic [2:0]  enable;
    logic [2:0]  miso;
    wire  [2:0]  sclk, cs_n, mosi, valid, busy, ovr;
    wire  [47:0] acc_all;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // Instance 0: nominal; 1: overrun-prone period; 2: fastest SCLK.
    acc_spi_reader #(.CLK_DIV(2), .SAMPLE_PERIOD(200), .REG_ADDR(7'h3B)) u_dut0 (
        .clk(clk), .reset_n(rst_n[0]), .enable(enable[0]), .spi_miso(miso[0]),
        .spi_sclk(sclk[0]), .spi_cs_n(cs_n[0]), .spi_mosi(mosi[0]),
        .acc_out(acc_all[15:0]), .acc_valid(valid[0]), .busy(busy[0]), .overrun(ovr[0]));
    acc_spi_reader #(.CLK_DIV(2), .SAMPLE_PERIOD(60), .REG_ADDR(7'h3B)) u_dut1 (
        .clk(clk), .reset_n(rst_n[1]), .enable(enable[1]), .spi_miso(miso[1]),
        .spi_sclk(sclk[1]), .spi_cs_n(cs_n[1]), .spi_mosi(mosi[1]),
        .acc_out(acc_all[31:16]), .acc_valid(valid[1]), .busy(busy[1]), .overrun(ovr[1]));
    acc_spi_reader #(.CLK_DIV(1), .SAMPLE_PERIOD(60), .REG_ADDR(7'h3B)) u_dut2 (
        .clk(clk), .reset_n(rst_n[2]), .enable(enable[2]), .spi_miso(miso[2]),
        .spi_sclk(sclk[2]), .spi_cs_n(cs_n[2]), .spi_mosi(mosi[2]),
        .acc_out(acc_all[47:32]), .acc_valid(valid[2]), .busy(busy[2]), .overrun(ovr[2]));

    // Per-instance sensor model and event log, sampled on the falling clk edge.
    logic [23:0] frame [3];
    logic [23:0] cur [3];
    logic [23:0] mframe [3];
    logic [15:0] last_acc [3];
    logic [15:0] p_acc [3];
    logic        p_cs [3];
    logic        p_sclk [3];
    int fall_t [3], prev_fall_t [3], falls [3], rises [3], low_len [3];
    int valids [3], valid_t [3], ovrs [3], bad_mosi [3], glitch [3], fidx [3];

    function automatic logic [15:0] acc_of(input int i);
        return acc_all[16*i +: 16];
    endfunction

    initial begin
        for (int i = 0; i < 3; i++) begin
            fall_t[i] = 0; prev_fall_t[i] = 0; falls[i] = 0; rises[i] = 0;
            low_len[i] = 0; valids[i] = 0; valid_t[i] = 0; ovrs[i] = 0;
            bad_mosi[i] = 0; glitch[i] = 0; fidx[i] = 0;
            mframe[i] = '0; cur[i] = '0; last_acc[i] = '0;
        end
    end

    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (!rst_n[i]) begin
                p_cs[i] = 1'b1; p_sclk[i] = 1'b1; p_acc[i] = acc_of(i); miso[i] = 1'b0;
            end else begin
                if (p_cs[i] && !cs_n[i]) begin
                    prev_fall_t[i] = fall_t[i]; fall_t[i] = cyc; falls[i]++;
                    rises[i] = 0; fidx[i] = 0; mframe[i] = '0; cur[i] = frame[i];
                end
                if (!cs_n[i] && p_sclk[i] && !sclk[i] && fidx[i] < 24) begin
                    miso[i] = cur[i][23 - fidx[i]];
                    fidx[i]++;
                end
                if (!cs_n[i] && !p_sclk[i] && sclk[i]) begin
                    rises[i]++;
                    mframe[i] = {mframe[i][22:0], mosi[i]};
                end
                if (!p_cs[i] && cs_n[i]) low_len[i] = cyc - fall_t[i];
                if (valid[i]) begin
                    valids[i]++; valid_t[i] = cyc; last_acc[i] = acc_of(i);
                end else if (acc_of(i) !== p_acc[i]) begin
                    glitch[i]++;
                end
                if (ovr[i]) ovrs[i]++;
                if (cs_n[i] && mosi[i]) bad_mosi[i]++;
                p_cs[i] = cs_n[i]; p_sclk[i] = sclk[i]; p_acc[i] = acc_of(i);
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_valid(input int i, input int target, input int budget, input string tag);
        int n = 0;
        while (valids[i] < target && n < budget) begin tick(); n++; end
        chk({tag, "_valid_seen"}, 32'(valids[i] >= target), 32'd1);
    endtask

    task automatic wait_fall(input int i, input int target, input int budget, input string tag);
        int n = 0;
        while (falls[i] < target && n < budget) begin tick(); n++; end
        chk({tag, "_fall_seen"}, 32'(falls[i] >= target), 32'd1);
    endtask

    localparam logic [23:0] C_MOSI_FRAME = {1'b1, 7'h3B, 16'h0000};

    initial begin
        int c, f, nv;
        logic [15:0] v;
        rst_n  = '0;
        enable = '0;
        for (int i = 0; i < 3; i++) frame[i] = {8'($urandom), 16'($urandom)};
        repeat (3) tick();
        chk("rst_sclk",  32'(sclk[0]),  32'd1);
        chk("rst_cs_n",  32'(cs_n[0]),  32'd1);
        chk("rst_mosi",  32'(mosi[0]),  32'd0);
        chk("rst_acc",   32'(acc_of(0)), 32'd0);
        chk("rst_valid", 32'(valid[0]), 32'd0);
        chk("rst_busy",  32'(busy[0]),  32'd0);
        chk("rst_ovr",   32'(ovr[0]),   32'd0);
        rst_n = '1;
        tick();

        // Nominal transaction and back-to-back samples
        frame[0] = {8'($urandom), 16'h8001};
        enable[0] = 1'b1; c = cyc;
        wait_valid(0, 1, 300, "t1");
        chk("t1_fall_time", 32'(fall_t[0]), 32'(c + 1));
        chk("t1_mosi_frame", 32'(mframe[0]), 32'(C_MOSI_FRAME));
        chk("t1_sclk_rises", 32'(rises[0]), 32'd24);
        chk("t1_cs_low", 32'(low_len[0]), 32'd100);
        chk("t1_latency", 32'(valid_t[0] - c), 32'd101);
        chk("t1_acc", 32'(last_acc[0]), 32'h8001);
        frame[0] = {8'($urandom), 16'h7FFF};
        wait_valid(0, 2, 250, "t2");
        chk("t2_acc", 32'(last_acc[0]), 32'h7FFF);
        chk("t2_period", 32'(fall_t[0] - prev_fall_t[0]), 32'd200);
        frame[0] = {8'($urandom), 16'h0000};
        wait_valid(0, 3, 250, "t3");
        chk("t3_acc", 32'(last_acc[0]), 32'h0000);
        for (int k = 0; k < 3; k++) begin
            v = 16'($urandom);
            frame[0] = {8'($urandom), v};
            wait_valid(0, 4 + k, 250, "rnd");
            chk("rnd_acc", 32'(last_acc[0]), 32'(v));
            chk("rnd_rises", 32'(rises[0]), 32'd24);
        end
        chk("d0_acc_hold", 32'(glitch[0]), 32'd0);
        chk("d0_mosi_idle", 32'(bad_mosi[0]), 32'd0);
        chk("d0_overrun", 32'(ovrs[0]), 32'd0);

        // Enable dropped mid-shift: transaction still completes
        v = 16'($urandom);
        frame[0] = {8'($urandom), v};
        wait_fall(0, falls[0] + 1, 250, "dis");
        repeat (30) tick();
        enable[0] = 1'b0;
        wait_valid(0, 7, 100, "dis");
        chk("dis_acc", 32'(last_acc[0]), 32'(v));
        f = falls[0];
        repeat (300) tick();
        chk("dis_no_fall", 32'(falls[0]), 32'(f));
        frame[0] = {8'($urandom), 16'($urandom)};
        enable[0] = 1'b1; c = cyc;
        wait_fall(0, f + 1, 5, "reen");
        chk("reen_fall_time", 32'(fall_t[0]), 32'(c + 1));

        // Reset around bit 12 of the shift
        repeat (50) tick();
        nv = valids[0];
        rst_n[0] = 1'b0;
        #1;
        chk("rmid_cs_n", 32'(cs_n[0]), 32'd1);
        chk("rmid_sclk", 32'(sclk[0]), 32'd1);
        chk("rmid_busy", 32'(busy[0]), 32'd0);
        chk("rmid_acc",  32'(acc_of(0)), 32'd0);
        chk("rmid_valid", 32'(valid[0]), 32'd0);
        repeat (3) tick();
        chk("rmid_no_valid", 32'(valids[0]), 32'(nv));
        v = 16'($urandom);
        frame[0] = {8'($urandom), v};
        rst_n[0] = 1'b1; c = cyc;
        wait_valid(0, nv + 1, 150, "rpost");
        chk("rpost_fall_time", 32'(fall_t[0]), 32'(c + 1));
        chk("rpost_acc", 32'(last_acc[0]), 32'(v));
        chk("rpost_cs_low", 32'(low_len[0]), 32'd100);
        chk("rpost_rises", 32'(rises[0]), 32'd24);
        enable[0] = 1'b0;

        // Short period: every other trigger lands in a transaction
        v = 16'($urandom);
        frame[1] = {8'($urandom), v};
        enable[1] = 1'b1;
        repeat (630) tick();
        enable[1] = 1'b0;
        repeat (200) tick();
        chk("ovr_falls", 32'(falls[1]), 32'd6);
        chk("ovr_valids", 32'(valids[1]), 32'd6);
        chk("ovr_pulses", 32'(ovrs[1]), 32'd5);
        chk("ovr_acc", 32'(last_acc[1]), 32'(v));
        chk("ovr_acc_hold", 32'(glitch[1]), 32'd0);

        // CLK_DIV=1 corner
        v = 16'($urandom);
        frame[2] = {8'($urandom), v};
        enable[2] = 1'b1; c = cyc;
        for (int k = 0; k < 4; k++) begin
            wait_valid(2, k + 1, 80, "div1");
            chk("div1_acc", 32'(last_acc[2]), 32'(v));
            chk("div1_rises", 32'(rises[2]), 32'd24);
            chk("div1_cs_low", 32'(low_len[2]), 32'd50);
            chk("div1_mosi_frame", 32'(mframe[2]), 32'(C_MOSI_FRAME));
            if (k == 0) chk("div1_latency", 32'(valid_t[2] - c), 32'd51);
            else        chk("div1_period", 32'(fall_t[2] - prev_fall_t[2]), 32'd60);
            v = 16'($urandom);
            frame[2] = {8'($urandom), v};
        end
        enable[2] = 1'b0;
        chk("div1_overrun", 32'(ovrs[2]), 32'd0);
        chk("div1_mosi_idle", 32'(bad_mosi[2]), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
